// File: rtl/branch_predict_unit.sv
// Branch predictor with misprediction recovery.
// 2-bit saturating counter table predicts at IF; EX resolution trains the
// table and, on a mismatch, raises a registered one-cycle redirect plus
// IF/ID and ID/EX flushes. A resolution arriving in the redirect cycle is
// wrong-path and dropped.
// Optional feature macro: BPU_STATS_EN adds saturating 16-bit
// branch/mispredict statistics outputs.
module branch_predict_unit #(
  parameter int INDEX_BITS = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_is_branch,
  input  logic [XLEN-1:0] if_imm,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_to_branch,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts
`endif
);

  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic {IDLE, REDIRECT} state_t;

  // Two-bit counter step that clamps at 0 and 3.
  function automatic logic [1:0] sat_ctr(input logic [1:0] cur, input logic up);
    logic [1:0] res;
    res = cur;
    if (up) begin
      if (cur != 2'b11) res = cur + 2'b01;
    end else begin
      if (cur != 2'b00) res = cur - 2'b01;
    end
    return res;
  endfunction

  // Sixteen-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cur);
    logic [15:0] res;
    res = (cur == 16'hFFFF) ? cur : cur + 16'd1;
    return res;
  endfunction

  logic [1:0]            ctr [DEPTH];
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  state_t                state, state_nxt;
  logic                  update_en;
  logic                  mispredict;
  logic [XLEN-1:0]       redirect_pc_nxt;
  logic                  redirect_p1;
  logic                  flush_if_id_p1;
  logic                  flush_id_ex_p1;
  logic [XLEN-1:0]       redirect_pc_p1;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];

  // Stage IF: combinational prediction from the pre-update table state.
  assign pred_taken  = if_is_branch && ctr[if_idx][1];
  assign pred_target = if_pc + if_imm;

  // Next-state, resolution acceptance and recovery address selection.
  always_comb begin
    state_nxt       = state;
    update_en       = 1'b0;
    mispredict      = 1'b0;
    redirect_pc_nxt = redirect_pc_p1;
    case (state)
      IDLE: begin
        update_en  = ex_valid;
        mispredict = ex_valid && (ex_pred_taken != ex_to_branch);
        if (mispredict) begin
          state_nxt       = REDIRECT;
          redirect_pc_nxt = ex_to_branch ? ex_target : ex_pc + PC_STEP;
        end
      end
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage EX -> table: train the counter of the resolving branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
    end else if (update_en) begin
      ctr[ex_idx] <= sat_ctr(ctr[ex_idx], ex_to_branch);
    end
  end

  // Stage EX -> p1: registered redirect and flush pulses with corrected PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_p1    <= 1'b0;
      flush_if_id_p1 <= 1'b0;
      flush_id_ex_p1 <= 1'b0;
      redirect_pc_p1 <= '0;
    end else begin
      redirect_p1    <= mispredict;
      flush_if_id_p1 <= mispredict;
      flush_id_ex_p1 <= mispredict;
      redirect_pc_p1 <= redirect_pc_nxt;
    end
  end

  assign redirect    = redirect_p1;
  assign flush_if_id = flush_if_id_p1;
  assign flush_id_ex = flush_id_ex_p1;
  assign redirect_pc = redirect_pc_p1;

`ifdef BPU_STATS_EN
  logic [15:0] branches_p1;
  logic [15:0] mispredicts_p1;

  // Saturating counts of processed resolutions and mispredicts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_p1    <= '0;
      mispredicts_p1 <= '0;
    end else begin
      if (update_en)  branches_p1    <= sat_inc16(branches_p1);
      if (mispredict) mispredicts_p1 <= sat_inc16(mispredicts_p1);
    end
  end

  assign stat_branches    = branches_p1;
  assign stat_mispredicts = mispredicts_p1;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: prediction, training, saturation,
// redirect pulses, same-cycle read/write ordering and asynchronous reset.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic [31:0] if_imm;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_to_branch;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
`ifdef BPU_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  branch_predict_unit #(.INDEX_BITS(4), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_pc         (if_pc),
    .if_is_branch  (if_is_branch),
    .if_imm        (if_imm),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_to_branch  (ex_to_branch),
    .ex_target     (ex_target),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex)
`ifdef BPU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic v, input logic [31:0] pc, input logic pt,
                         input logic tb, input logic [31:0] tgt);
    ex_valid      = v;
    ex_pc         = pc;
    ex_pred_taken = pt;
    ex_to_branch  = tb;
    ex_target     = tgt;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    if_pc = '0; if_is_branch = 1'b0; if_imm = '0;
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_redirect", {31'b0, redirect}, 32'd0);
    chk("rst_flush_if_id", {31'b0, flush_if_id}, 32'd0);
    chk("rst_flush_id_ex", {31'b0, flush_id_ex}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    reset = 1'b0;
`ifdef BPU_STATS_EN
    chk("rst_stat_br", {16'b0, stat_branches}, 32'd0);
    chk("rst_stat_mp", {16'b0, stat_mispredicts}, 32'd0);
`endif

    // Initial prediction: weakly not-taken.
    if_pc = 32'h40; if_is_branch = 1'b1; if_imm = 32'h10;
    #1;
    chk("init_pred", {31'b0, pred_taken}, 32'd0);
    chk("init_target", pred_target, 32'h50);
    chk("init_redirect", {31'b0, redirect}, 32'd0);

    // Taken mispredict at 0x40, held for a second cycle that falls in REDIRECT.
    tick();
    resolve(1'b1, 32'h40, 1'b0, 1'b1, 32'h80);
    tick();
    chk("mp1_redirect", {31'b0, redirect}, 32'd1);
    chk("mp1_pc", redirect_pc, 32'h80);
    chk("mp1_flush_if_id", {31'b0, flush_if_id}, 32'd1);
    chk("mp1_flush_id_ex", {31'b0, flush_id_ex}, 32'd1);
    chk("mp1_pred", {31'b0, pred_taken}, 32'd1);
    tick();
    chk("drop_redirect", {31'b0, redirect}, 32'd0);
    chk("drop_pc_hold", redirect_pc, 32'h80);
    // One not-taken step: counter 2 -> 1 predicts not-taken (3 -> 2 would not).
    resolve(1'b1, 32'h40, 1'b0, 1'b0, 32'h80);
    tick();
    chk("after_drop_pred", {31'b0, pred_taken}, 32'd0);
    chk("correct_nt_redirect", {31'b0, redirect}, 32'd0);
    resolve(1'b1, 32'h40, 1'b1, 1'b1, 32'h80);
    tick();
    chk("third_taken_pred", {31'b0, pred_taken}, 32'd1);
    chk("correct_t_redirect", {31'b0, redirect}, 32'd0);

    // Saturate high: 2 -> 3 -> 3, then down 2, 1.
    tick();
    chk("sat_hi_a", {31'b0, pred_taken}, 32'd1);
    tick();
    chk("sat_hi_b", {31'b0, pred_taken}, 32'd1);
    resolve(1'b1, 32'h40, 1'b0, 1'b0, 32'h80);
    tick();
    chk("sat_hi_down1", {31'b0, pred_taken}, 32'd1);
    tick();
    chk("sat_hi_down2", {31'b0, pred_taken}, 32'd0);

    // Saturate low at index 1: 1 -> 0 -> 0, then up 1, 2.
    if_pc = 32'h44;
    resolve(1'b1, 32'h44, 1'b0, 1'b0, 32'h0);
    tick();
    chk("sat_lo_a", {31'b0, pred_taken}, 32'd0);
    tick();
    chk("sat_lo_b", {31'b0, pred_taken}, 32'd0);
    resolve(1'b1, 32'h44, 1'b1, 1'b1, 32'h0);
    tick();
    chk("sat_lo_up1", {31'b0, pred_taken}, 32'd0);
    tick();
    chk("sat_lo_up2", {31'b0, pred_taken}, 32'd1);

    // Predicted taken, actually not-taken: fall-through redirect.
    resolve(1'b1, 32'h100, 1'b1, 1'b0, 32'h200);
    tick();
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("nt_redirect", {31'b0, redirect}, 32'd1);
    chk("nt_pc", redirect_pc, 32'h104);
    chk("nt_flush_if_id", {31'b0, flush_if_id}, 32'd1);
    chk("nt_flush_id_ex", {31'b0, flush_id_ex}, 32'd1);
    tick();
    chk("nt_redirect_end", {31'b0, redirect}, 32'd0);
    chk("nt_flush_if_id_end", {31'b0, flush_if_id}, 32'd0);
    chk("nt_flush_id_ex_end", {31'b0, flush_id_ex}, 32'd0);
    chk("nt_pc_hold", redirect_pc, 32'h104);

    // Same-cycle read and write of index 2 (counter 1, taken update).
    if_pc = 32'h48;
    resolve(1'b1, 32'h48, 1'b0, 1'b1, 32'h300);
    #1;
    chk("rw_same_cycle", {31'b0, pred_taken}, 32'd0);
    tick();
    resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rw_next_cycle", {31'b0, pred_taken}, 32'd1);
    chk("rw_redirect", {31'b0, redirect}, 32'd1);
    chk("rw_pc", redirect_pc, 32'h300);
    if_is_branch = 1'b0;
    #1;
    chk("non_branch_pred", {31'b0, pred_taken}, 32'd0);
    if_pc = 32'hFFFF_FFF0; if_imm = 32'h20;
    #1;
    chk("target_wrap", pred_target, 32'h10);

    // Asynchronous reset in the middle of the REDIRECT cycle.
    reset = 1'b1;
    #1;
    chk("async_redirect", {31'b0, redirect}, 32'd0);
    chk("async_flush_if_id", {31'b0, flush_if_id}, 32'd0);
    chk("async_flush_id_ex", {31'b0, flush_id_ex}, 32'd0);
    chk("async_pc", redirect_pc, 32'h0);
    if_pc = 32'h48; if_is_branch = 1'b1; if_imm = 32'h0;
    #1;
    chk("async_table", {31'b0, pred_taken}, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_redirect", {31'b0, redirect}, 32'd0);

`ifdef BPU_STATS_EN
    chk("stat_br_clear", {16'b0, stat_branches}, 32'd0);
    for (int i = 0; i < 65537; i++) begin
      resolve(1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
      tick();
      resolve(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk("stat_mp_sat", {16'b0, stat_mispredicts}, 32'h0000FFFF);
    chk("stat_br_sat", {16'b0, stat_branches}, 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Fetch-side branch predictor and misprediction recovery controller for the 5-stage RISC-V pipeline. Predicts conditional branches at IF using a table of 2-bit saturating counters. At EX it compares the prediction with the resolved outcome (`to_branch` from the EX-stage branch decision logic). On a mismatch it issues a registered one-cycle redirect plus IF/ID and ID/EX flushes.

## Interface
Parameters:
- `INDEX_BITS`, 4: table index width; table depth is 2^INDEX_BITS entries.
- `XLEN`, 32: PC/address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_pc`  in  XLEN  PC of the instruction in IF.
- `if_is_branch`  in  1  predecoded: IF instruction opcode is 7'b1100011.
- `if_imm`  in  XLEN  sign-extended B-type immediate of the IF instruction.
- `pred_taken`  out  1  combinational prediction for the IF instruction.
- `pred_target`  out  XLEN  combinational, `if_pc + if_imm`.
- `ex_valid`  in  1  a conditional branch is resolving in EX this cycle.
- `ex_pc`  in  XLEN  PC of the EX branch.
- `ex_pred_taken`  in  1  prediction carried down the pipe with the EX branch.
- `ex_to_branch`  in  1  actual outcome from the branch decision logic.
- `ex_target`  in  XLEN  computed taken target of the EX branch.
- `redirect`  out  1  registered; fetch must load `redirect_pc`.
- `redirect_pc`  out  XLEN  registered corrected fetch address.
- `flush_if_id`  out  1  registered; squash the IF/ID register.
- `flush_id_ex`  out  1  registered; squash the ID/EX register.

## Operation
- Table: 2^INDEX_BITS 2-bit counters, indexed by `pc[INDEX_BITS+1:2]`. A counter value of 2 or 3 means taken.
- Prediction: `pred_taken = if_is_branch && ctr[if_idx][1]`. When `if_is_branch` = 0, `pred_taken` = 0. `pred_target` is always driven, computed with wrap-around modulo 2^XLEN.
- Update (state IDLE, `ex_valid` = 1):
  - The counter at the `ex_pc` index increments when `ex_to_branch` = 1 and decrements otherwise.
  - The counter saturates at 0 and at 3.
- Mispredict = `ex_valid && state==IDLE && (ex_pred_taken != ex_to_branch)`.
- FSM has two states, IDLE and REDIRECT:
  - IDLE → REDIRECT on a mispredict. Registered on that edge:
    - `redirect`, `flush_if_id` and `flush_id_ex` go to 1.
    - `redirect_pc` = `ex_to_branch ? ex_target : ex_pc + 4`.
  - REDIRECT → IDLE unconditionally after one cycle; all three pulse outputs return to 0.
  - While in REDIRECT, `ex_valid` is ignored: the EX instruction is wrong-path, so there is no table update, no mispredict and no statistics.
- `redirect_pc` holds its last value when `redirect` = 0.
- Same-cycle read/write of the same index: the prediction uses the pre-update value. There is no bypass.
- Reset values:
  - Every counter = 2'b01 (weakly not-taken).
  - state = IDLE.
  - `redirect` = `flush_if_id` = `flush_id_ex` = 0; `redirect_pc` = 0.
  - Statistics counters = 0.
- A reset asserted mid-REDIRECT clears the state immediately and asynchronously, and all outputs drop to 0 without waiting for a clock edge.

## Timing
- Prediction latency: 0 cycles (combinational from `if_pc`, `if_is_branch`, `if_imm` and table state).
- Mispredict at EX in cycle N → `redirect`, `flush_if_id` and `flush_id_ex` are high for exactly cycle N+1.
- Table update from a cycle-N resolution is visible to prediction from cycle N+1.
- Back-to-back: a resolution presented in cycle N+1 (during REDIRECT) is dropped. A resolution in cycle N+2 is processed normally.
- Minimum spacing between two redirects: 2 cycles.

## Configuration
- `BPU_STATS_EN` defined:
  - Adds outputs `stat_branches` (16 bits) and `stat_mispredicts` (16 bits).
  - `stat_branches` increments on each processed resolution; `stat_mispredicts` increments on each mispredict.
  - Both saturate at 16'hFFFF and reset to 0.
- `BPU_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then `if_pc`=0x40, `if_is_branch`=1, `if_imm`=0x10 → `pred_taken`=0, `pred_target`=0x50; `redirect`=0.
- Two resolutions at `ex_pc`=0x40, taken, `ex_pred_taken`=0 → the first produces `redirect`=1 one cycle later with `redirect_pc`=`ex_target`. The second, issued in the REDIRECT cycle, is ignored (counter ends at 2, not 3). A third taken resolution at the same index gives `pred_taken`=1 for `if_pc`=0x40.
- Counter already at 3 with a taken update, and counter at 0 with a not-taken update → both stay saturated. A subsequent single opposite update gives 2 and 1 respectively.
- `ex_pred_taken`=1, `ex_to_branch`=0, `ex_pc`=0x100 → next cycle `redirect_pc`=0x104 and both flushes high for exactly one cycle.
- Same-cycle `if_pc` and `ex_pc` at the same index, counter at 1, taken update → `pred_taken`=0 in that cycle and 1 in the next.
- Assert `reset` asynchronously during the REDIRECT cycle → `redirect`/flush outputs go to 0 before the next edge. With `BPU_STATS_EN` defined, 65 537 mispredicts → `stat_mispredicts`=16'hFFFF.
